// File: rtl/regfile_scanner.sv
// regfile_scanner: debug read-out engine for the pipeline register file.
// On a start pulse it walks addresses FIRST..LAST on the regfile's spare read
// port. Each captured value is presented as an {address, data} beat on a
// valid/ready stream. A one-cycle done pulse follows the final beat.
//
// Optional feature macro: SCAN_SKIP_ZERO_EN
//   defined   -> registers that read as zero are skipped and produce no beat
//                (1 cycle each); done still pulses at the end of the range.
//   undefined -> every address in the range produces exactly one beat.
module regfile_scanner #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int FIRST  = 0,
  parameter int LAST   = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] L_FIRST = ADDR_W'(FIRST);
  localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(LAST);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cur;
  logic                r_outValid;
  logic [ADDR_W-1:0]   r_outAddr;
  logic [DATA_W-1:0]   r_outData;
  logic                r_busy;
  logic                r_done;

  logic                w_atLast;
  logic                w_skip;
  logic [ADDR_W-1:0]   w_nextCur;

  // The scan ends on an equality compare with LAST, so the increment never
  // needs to wrap even when LAST is the top of the address space.
  assign w_atLast  = (r_cur == L_LAST);
  assign w_nextCur = r_cur + ADDR_W'(1);

`ifdef SCAN_SKIP_ZERO_EN
  assign w_skip = (rd_data == '0);
`else
  assign w_skip = 1'b0;
`endif

  // Scan sequencer: walks the address range, captures read data into the
  // beat registers, holds the beat until the sink accepts it, then pulses done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cur      <= L_FIRST;
      r_outValid <= 1'b0;
      r_outAddr  <= '0;
      r_outData  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_cur   <= L_FIRST;
            r_busy  <= 1'b1;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          if (w_skip) begin
            if (w_atLast) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cur <= w_nextCur;
            end
          end else begin
            r_outAddr  <= r_cur;
            r_outData  <= rd_data;
            r_outValid <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            r_outValid <= 1'b0;
            if (w_atLast) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cur   <= w_nextCur;
              r_state <= S_READ;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_cur   <= L_FIRST;
          r_state <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_cur      <= L_FIRST;
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign rd_addr   = r_cur;
  assign out_valid = r_outValid;
  assign out_addr  = r_outAddr;
  assign out_data  = r_outData;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_regfile_scanner.sv
// Testbench for regfile_scanner: a behavioural regfile drives the read port,
// and a list-based reference model predicts the beat sequence and done timing.
module tb_regfile_scanner;

  localparam int FIRST = 0;
  localparam int LAST  = 31;
`ifdef SCAN_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;
  logic        outValid;
  logic        outReady;
  logic [4:0]  outAddr;
  logic [31:0] outData;
  logic        busy;
  logic        done;

  logic        wrEn;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [31:0] regs [32];

  logic [31:0] mdl [32];
  int          expA[$];
  logic [31:0] expD[$];
  int          expCycles;
  int          gotA[$];
  logic [31:0] gotD[$];

  int checks   = 0;
  int failures = 0;

  regfile_scanner #(.ADDR_W(5), .DATA_W(32), .FIRST(FIRST), .LAST(LAST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rd_addr  (rdAddr),
    .rd_data  (rdData),
    .out_valid(outValid),
    .out_ready(outReady),
    .out_addr (outAddr),
    .out_data (outData),
    .busy     (busy),
    .done     (done)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CPU side of the regfile: writes land on the rising edge, reads are combinational.
  always @(posedge clk) begin
    if (wrEn) regs[wrAddr] <= wrData;
  end
  assign rdData = regs[rdAddr];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Copy the model contents into the regfile through its write port.
  task automatic loadAll();
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      wrEn = 1'b1; wrAddr = 5'(a); wrData = mdl[a];
    end
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  // Expected beats: every address in range, minus zero-valued ones when skipping.
  // Cost with ready held high: 2 cycles per beat, 1 per skip, done the cycle after.
  task automatic buildExpected();
    expA.delete(); expD.delete();
    expCycles = 0;
    for (int a = FIRST; a <= LAST; a++) begin
      if (SKIP && mdl[a] == 32'h0) begin
        expCycles += 1;
      end else begin
        expA.push_back(a);
        expD.push_back(mdl[a]);
        expCycles += 2;
      end
    end
    expCycles += 1;
  endtask

  task automatic compareBeats(input string tag);
    int n;
    checkOutput({tag, "_count"}, 32'(gotA.size()), 32'(expA.size()));
    n = (gotA.size() < expA.size()) ? gotA.size() : expA.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_addr"}, 32'(gotA[i]), 32'(expA[i]));
      checkOutput({tag, "_data"}, gotD[i], expD[i]);
    end
  endtask

  // One scan, observed at falling edges. n counts cycles after the start edge.
  // wrMode 1: CPU writes r5 early; wrMode 2: write lands on r5's read edge.
  task automatic applyStimulus(input int stallAddr, input int stallLen, input bit randReady,
                               input int restartAt, input int wrMode, output int doneAt);
    int  stalled;
    int  relN;
    bit  wrFired;
    gotA.delete(); gotD.delete();
    doneAt = -1; stalled = 0; relN = -1; wrFired = 1'b0;
    @(negedge clk);
    outReady = 1'b1;
    start    = 1'b1;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      start = 1'b0;
      wrEn  = 1'b0;
      if (done) begin
        doneAt = n;
        break;
      end
      if (n == restartAt) start = 1'b1;
      if (wrMode == 1 && n == 4) begin
        wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'h12345678;
      end
      if (wrMode == 2 && !wrFired && busy && rdAddr == 5'd5) begin
        wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'hCAFEF00D; wrFired = 1'b1;
      end
      if (relN > 0 && n == relN + 1) checkOutput("releaseGap", 32'(outValid), 32'd0);
      if (relN > 0 && n == relN + 2) checkOutput("releaseNext", 32'(outValid), 32'd1);
      if (outValid && stallAddr >= 0 && 32'(outAddr) == stallAddr && stalled < stallLen) begin
        outReady = 1'b0;
        stalled++;
        checkOutput("stallValid", 32'(outValid), 32'd1);
        checkOutput("stallAddr", 32'(outAddr), 32'(stallAddr));
        checkOutput("stallData", outData, mdl[stallAddr]);
      end else begin
        outReady = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (outValid && outReady) begin
        gotA.push_back(32'(outAddr));
        gotD.push_back(outData);
        if (stallLen > 0 && stalled == stallLen && relN < 0) relN = n;
      end
    end
    if (doneAt < 0) begin
      checkOutput("scanTimeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
      checkOutput("busyAfterDone", 32'(busy), 32'd0);
      checkOutput("doneOneCycle", 32'(done), 32'd0);
    end
    outReady = 1'b1;
  endtask

  initial begin
    int  d;
    bit  found;
    bit  sawDone;
    rst_n = 1'b0; start = 1'b0; outReady = 1'b0;
    wrEn = 1'b0; wrAddr = '0; wrData = '0;
    for (int a = 0; a < 32; a++) mdl[a] = 32'h0;

    // Reset state, with start pulses issued while held in reset.
    repeat (2) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    checkOutput("rstValid", 32'(outValid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstRdAddr", 32'(rdAddr), 32'(FIRST));
    checkOutput("rstOutAddr", 32'(outAddr), 32'd0);
    checkOutput("rstOutData", outData, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idleBusy", 32'(busy), 32'd0);
    checkOutput("idleValid", 32'(outValid), 32'd0);

    // Preloaded r1/r2, ready held high.
    mdl[1] = 32'hFFFFFFFF; mdl[2] = 32'h88888888;
    loadAll(); buildExpected();
    applyStimulus(-1, 0, 1'b0, 0, 0, d);
    compareBeats("preload");
    checkOutput("preloadDoneCycle", 32'(d), 32'(expCycles));

    // Backpressure on beat 2 for 10 cycles.
    mdl[3] = 32'h00000033;
    loadAll(); buildExpected();
    applyStimulus(2, 10, 1'b0, 0, 0, d);
    compareBeats("stall");
    checkOutput("stallDoneCycle", 32'(d), 32'(expCycles + 10));

    // Restart attempt mid-scan plus an early CPU write to r5.
    mdl[5] = 32'h00000055;
    loadAll();
    mdl[5] = 32'h12345678;
    buildExpected();
    applyStimulus(-1, 0, 1'b0, 3, 1, d);
    compareBeats("restartWrite");
    checkOutput("restartDoneCycle", 32'(d), 32'(expCycles));

    // CPU write on r5's capture edge: the old value is carried.
    buildExpected();
    applyStimulus(-1, 0, 1'b0, 0, 2, d);
    compareBeats("sameEdgeWrite");
    mdl[5] = 32'hCAFEF00D;

    // Reset dropped while beat 7 is waiting in SEND.
    mdl[7] = 32'h00000077;
    loadAll();
    @(negedge clk); start = 1'b1; outReady = 1'b1; found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (outValid && outAddr == 5'd7) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("midRstReachedBeat7", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 32'(outValid), 32'd0);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstRdAddr", 32'(rdAddr), 32'(FIRST));
    sawDone = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("midRstNoDone", 32'(sawDone), 32'd0);
    rst_n = 1'b1;
    buildExpected();
    applyStimulus(-1, 0, 1'b0, 0, 0, d);
    compareBeats("afterRst");
    checkOutput("afterRstDoneCycle", 32'(d), 32'(expCycles));

    // Random register contents with random sink backpressure.
    repeat (2) begin
      for (int a = 0; a < 32; a++) mdl[a] = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
      loadAll(); buildExpected();
      applyStimulus(-1, 0, 1'b1, 0, 0, d);
      compareBeats("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
